// File: rtl/delayline_flow_ctrl.sv
// delayline_flow_ctrl
// Valid/ready flow control around a fixed-latency datapath made of delaylines
// that share a single enable. A valid shift register follows the tokens in
// flight. Tokens that leave the datapath are captured in a credit-protected
// output FIFO, so downstream back-pressure can never drop data.
// FIFO organisation: one registered head slot (out_vld/out_d) backed by a
// circular buffer of D entries. Pointers wrap modulo D. Full and empty come
// from an explicit count, so D does not have to be a power of two.

module delayline_flow_ctrl #(
    parameter int W = 4,
    parameter int L = 10,
    parameter int D = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   hold,
    input  logic                   in_vld,
    output logic                   in_rdy,
    output logic                   pipe_ena,
    input  logic [W-1:0]           pipe_q,
    output logic                   out_vld,
    input  logic                   out_rdy,
    output logic [W-1:0]           out_d,
    output logic [$clog2(D+1)-1:0] occ
);

    localparam int OW = $clog2(D + 1);
    localparam int PW = (D > 1) ? $clog2(D) : 1;

    // valid tag for each datapath stage; vsr[L-1] lines up with pipe_q
    logic [L-1:0]  vsr;

    logic          accept;
    logic          push;
    logic          pop;
    logic          head_free;
    logic          mem_empty;
    logic          mem_rd;
    logic          mem_wr;

    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [OW-1:0] cnt;
    logic [OW:0]   fifo_used;

    logic [W-1:0]  mem [D];

    // Circular pointer advance that wraps at D, whether or not D is a power of two
    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        if (p == PW'(D - 1)) begin
            return '0;
        end
        return p + PW'(1);
    endfunction

    // Credit counter update: a new token claims a credit, a pop returns one
    function automatic logic [OW-1:0] occ_next(input logic [OW-1:0] cur,
                                               input logic          take,
                                               input logic          give);
        logic [OW-1:0] nxt;
        nxt = cur;
        if (take && !give) begin
            nxt = cur + OW'(1);
        end else if (!take && give) begin
            nxt = cur - OW'(1);
        end
        return nxt;
    endfunction

    // Handshake decode and FIFO steering. Nothing here depends on in_vld except accept.
    always_comb begin
        pipe_ena  = ~hold;
        in_rdy    = ~rst & ~hold & (occ < OW'(D));
        accept    = in_vld & in_rdy;
        push      = vsr[L-1] & pipe_ena;
        pop       = out_vld & out_rdy;
        head_free = ~out_vld | out_rdy;
        mem_empty = (cnt == '0);
        // Refill the head from the buffer first, so the buffered tokens stay ahead of a new push
        mem_rd    = head_free & ~mem_empty;
        // A push goes straight into the head only when both the head and the buffer are free
        mem_wr    = push & ~(head_free & mem_empty);
        fifo_used = {1'b0, cnt} + {{OW{1'b0}}, out_vld};
    end

    // Valid shift register. It moves in lock-step with the delaylines and freezes on hold.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vsr <= '0;
        end else if (pipe_ena) begin
            vsr[0] <= accept;
            for (int i = 1; i < L; i++) begin
                vsr[i] <= vsr[i-1];
            end
        end
    end

    // Credits in use: tokens in flight plus tokens held anywhere in the FIFO
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            occ <= '0;
        end else begin
            occ <= occ_next(occ, accept, pop);
        end
    end

    // FIFO control: pointers, buffer count and the registered head slot
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            cnt     <= '0;
            out_vld <= 1'b0;
            out_d   <= '0;
        end else begin
            if (mem_wr) begin
                wr_ptr <= ptr_inc(wr_ptr);
            end
            if (mem_rd) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
            if (mem_wr && !mem_rd) begin
                cnt <= cnt + OW'(1);
            end else if (!mem_wr && mem_rd) begin
                cnt <= cnt - OW'(1);
            end
            if (head_free) begin
                if (mem_rd) begin
                    out_vld <= 1'b1;
                    out_d   <= mem[rd_ptr];
                end else if (push) begin
                    out_vld <= 1'b1;
                    out_d   <= pipe_q;
                end else begin
                    out_vld <= 1'b0;
                end
            end
        end
    end

    // Buffer storage. It is data only, so it has no reset.
    always_ff @(posedge clk) begin
        if (mem_wr) begin
            mem[wr_ptr] <= pipe_q;
        end
    end

    // Credits are reserved at accept time, so a push can never find the FIFO full
    a_no_push_full: assert property (@(posedge clk) disable iff (rst)
                                     push |-> (fifo_used < (OW+1)'(D)));

    // The credit count never goes past the FIFO depth
    a_occ_bound: assert property (@(posedge clk) disable iff (rst)
                                  occ <= OW'(D));

endmodule

// File: tb/tb_delayline_flow_ctrl.sv
// Testbench for delayline_flow_ctrl. Instance A (D=16) runs the directed
// scenarios. Instance B (D=5) runs the randomized flow scenario. Each instance
// drives a behavioural delayline chain that shares the DUT's pipe_ena. Accepted
// tokens go into a scoreboard queue, and a monitor pops the queue on every
// output handshake.

module tb_delayline_flow_ctrl;

    localparam int W   = 4;
    localparam int L   = 10;
    localparam int DA  = 16;
    localparam int DB  = 5;
    localparam int OWA = $clog2(DA + 1);
    localparam int OWB = $clog2(DB + 1);

    logic clk = 1'b0;
    logic rst = 1'b1;

    logic           hold_a, in_vld_a, in_rdy_a, pipe_ena_a, out_vld_a, out_rdy_a;
    logic [W-1:0]   in_d_a, pipe_q_a, out_d_a;
    logic [OWA-1:0] occ_a;

    logic           hold_b, in_vld_b, in_rdy_b, pipe_ena_b, out_vld_b, out_rdy_b;
    logic [W-1:0]   in_d_b, pipe_q_b, out_d_b;
    logic [OWB-1:0] occ_b;

    logic [W-1:0] dl_a [L];
    logic [W-1:0] dl_b [L];

    logic [W-1:0] sb_a [$];
    logic [W-1:0] sb_b [$];

    int n_tests = 0;
    int n_fail  = 0;
    int n_acc_b = 0;
    int n_pop_b = 0;

    assign pipe_q_a = dl_a[L-1];
    assign pipe_q_b = dl_b[L-1];

    delayline_flow_ctrl #(.W(W), .L(L), .D(DA)) u_dut_a (
        .clk(clk), .rst(rst), .hold(hold_a), .in_vld(in_vld_a), .in_rdy(in_rdy_a),
        .pipe_ena(pipe_ena_a), .pipe_q(pipe_q_a), .out_vld(out_vld_a),
        .out_rdy(out_rdy_a), .out_d(out_d_a), .occ(occ_a)
    );

    delayline_flow_ctrl #(.W(W), .L(L), .D(DB)) u_dut_b (
        .clk(clk), .rst(rst), .hold(hold_b), .in_vld(in_vld_b), .in_rdy(in_rdy_b),
        .pipe_ena(pipe_ena_b), .pipe_q(pipe_q_b), .out_vld(out_vld_b),
        .out_rdy(out_rdy_b), .out_d(out_d_b), .occ(occ_b)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // delayline chain models: the upstream data enters stage 0, and everything shifts on pipe_ena
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < L; i++) dl_a[i] <= '0;
        end else if (pipe_ena_a) begin
            dl_a[0] <= in_d_a;
            for (int i = 1; i < L; i++) dl_a[i] <= dl_a[i-1];
        end
    end

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < L; i++) dl_b[i] <= '0;
        end else if (pipe_ena_b) begin
            dl_b[0] <= in_d_b;
            for (int i = 1; i < L; i++) dl_b[i] <= dl_b[i-1];
        end
    end

    // issue side: record every token that will be accepted on the coming edge
    always @(negedge clk) begin
        if (!rst) begin
            if (in_vld_a && in_rdy_a) sb_a.push_back(in_d_a);
            if (in_vld_b && in_rdy_b) begin
                sb_b.push_back(in_d_b);
                n_acc_b++;
            end
        end
    end

    // monitor side: every output handshake must match the oldest recorded token
    always @(negedge clk) begin
        logic [W-1:0] exp;
        if (!rst) begin
            if (out_vld_a && out_rdy_a) begin
                if (sb_a.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL a_out_d: got output %0h, expected no output", out_d_a);
                end else begin
                    exp = sb_a.pop_front();
                    check("a_out_d", int'(out_d_a), int'(exp));
                end
            end
            if (out_vld_b && out_rdy_b) begin
                n_pop_b++;
                if (sb_b.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL b_out_d: got output %0h, expected no output", out_d_b);
                end else begin
                    exp = sb_b.pop_front();
                    check("b_out_d", int'(out_d_b), int'(exp));
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int k, lat, cnt, first, last, max_occ, drops, pops, acc, viol;

        hold_a = 0; in_vld_a = 0; in_d_a = '0; out_rdy_a = 1;
        hold_b = 0; in_vld_b = 0; in_d_b = '0; out_rdy_b = 1;

        // reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_out_vld", int'(out_vld_a), 0);
        check("rst_out_d",   int'(out_d_a),   0);
        check("rst_occ",     int'(occ_a),     0);
        check("rst_in_rdy",  int'(in_rdy_a),  0);
        check("rst_occ_b",   int'(occ_b),     0);
        rst = 0;
        tick();
        check("post_rst_in_rdy", int'(in_rdy_a), 1);

        // test 1: single token latency
        in_vld_a = 1; in_d_a = 4'hA;
        tick();
        in_vld_a = 0;
        check("t1_occ_after_accept", int'(occ_a), 1);
        lat = -1;
        for (int i = 1; i <= 3 * L; i++) begin
            tick();
            if (out_vld_a) begin
                lat = i;
                break;
            end
        end
        check("t1_accept_to_outvld_edges", lat, L);
        check("t1_out_d", int'(out_d_a), 'hA);
        tick();
        check("t1_out_vld_drop", int'(out_vld_a), 0);
        check("t1_occ_final", int'(occ_a), 0);

        // test 2: 100 back-to-back tokens
        cnt = 0; first = -1; last = -1; max_occ = 0; drops = 0;
        for (int i = 0; i < 100 + L + 5; i++) begin
            if (i < 100) begin
                in_vld_a = 1;
                in_d_a = W'(i % 16);
                if (!in_rdy_a) drops++;
            end else begin
                in_vld_a = 0;
            end
            tick();
            if (int'(occ_a) > max_occ) max_occ = int'(occ_a);
            if (out_vld_a) begin
                cnt++;
                if (first < 0) first = i;
                last = i;
            end
        end
        check("t2_in_rdy_drops", drops, 0);
        check("t2_out_count", cnt, 100);
        check("t2_out_contiguous", last - first + 1, 100);
        check("t2_max_occ", max_occ, L + 1);
        check("t2_sb_empty", sb_a.size(), 0);

        // test 3: back-pressure fills all credits
        out_rdy_a = 0; acc = 0;
        for (int i = 0; i < 30; i++) begin
            in_vld_a = 1;
            in_d_a = W'(i % 16);
            if (in_rdy_a) acc++;
            tick();
        end
        in_vld_a = 0;
        check("t3_accepted", acc, DA);
        check("t3_in_rdy_full", int'(in_rdy_a), 0);
        check("t3_occ_full", int'(occ_a), DA);
        check("t3_out_vld_stalled", int'(out_vld_a), 1);
        check("t3_out_d_stalled", int'(out_d_a), int'(sb_a[0]));
        out_rdy_a = 1; pops = 0;
        for (int i = 0; i < 25; i++) begin
            if (out_vld_a && out_rdy_a) pops++;
            tick();
        end
        check("t3_pops", pops, DA);
        check("t3_sb_empty", sb_a.size(), 0);
        check("t3_occ_drained", int'(occ_a), 0);

        // test 4: hold while a token sits at stage L-1, with the FIFO draining
        out_rdy_a = 0;
        in_vld_a = 1; in_d_a = 4'h3; tick();
        in_d_a = 4'h5; tick();
        in_d_a = 4'hB; tick();
        in_vld_a = 0;
        k = 0;
        repeat (L - 1) begin
            tick();
            k++;
        end
        check("t4_occ_before_hold", int'(occ_a), 3);
        check("t4_out_vld_before_hold", int'(out_vld_a), 1);
        hold_a = 1; out_rdy_a = 1; in_vld_a = 1; in_d_a = 4'hF;
        #1;
        pops = 0;
        for (int i = 0; i < 3; i++) begin
            check("t4_pipe_ena_hold", int'(pipe_ena_a), 0);
            check("t4_in_rdy_hold", int'(in_rdy_a), 0);
            if (out_vld_a && out_rdy_a) pops++;
            tick();
            k++;
        end
        check("t4_pops_during_hold", pops, 2);
        hold_a = 0; in_vld_a = 0;
        lat = -1;
        for (int i = 0; i < 10; i++) begin
            tick();
            k++;
            if (out_vld_a) begin
                lat = k;
                break;
            end
        end
        check("t4_accept_to_outvld_edges", lat, L + 3);
        check("t4_out_d", int'(out_d_a), 'hB);
        tick();
        check("t4_single_push", int'(out_vld_a), 0);
        check("t4_sb_empty", sb_a.size(), 0);

        // test 5: asynchronous reset with 7 credits in use
        out_rdy_a = 0;
        for (int i = 0; i < 7; i++) begin
            in_vld_a = 1;
            in_d_a = W'(i + 1);
            tick();
        end
        in_vld_a = 0;
        repeat (5) tick();
        check("t5_occ_before_rst", int'(occ_a), 7);
        check("t5_out_vld_before_rst", int'(out_vld_a), 1);
        #3 rst = 1;
        #1;
        check("t5_rst_out_vld", int'(out_vld_a), 0);
        check("t5_rst_occ", int'(occ_a), 0);
        check("t5_rst_out_d", int'(out_d_a), 0);
        check("t5_rst_in_rdy", int'(in_rdy_a), 0);
        sb_a.delete();
        #1 rst = 0;
        tick();
        out_rdy_a = 1; cnt = 0;
        for (int i = 0; i < 2 * L; i++) begin
            tick();
            if (out_vld_a) cnt++;
        end
        check("t5_no_stale_output", cnt, 0);
        check("t5_in_rdy_after_rst", int'(in_rdy_a), 1);

        // test 6: randomized flow on the D=5 instance
        viol = 0;
        for (int i = 0; i < 10000; i++) begin
            in_vld_b  = ($urandom_range(0, 3) != 0);
            in_d_b    = W'($urandom);
            out_rdy_b = ($urandom_range(0, 1) != 0);
            hold_b    = ($urandom_range(0, 7) == 0);
            tick();
            if (int'(occ_b) > DB) viol++;
        end
        hold_b = 0; in_vld_b = 0; out_rdy_b = 1;
        repeat (4 * L) tick();
        check("t6_occ_bound_violations", viol, 0);
        check("t6_sb_empty", sb_b.size(), 0);
        check("t6_delivered_eq_accepted", n_pop_b, n_acc_b);
        check("t6_progress", int'(n_pop_b > 1000), 1);
        check("t6_occ_final", int'(occ_b), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
